// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the regfile_nport register file.
package rf_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 2;

    // All-zero data word, resized by users to their own WIDTH.
    localparam logic [DEF_WIDTH-1:0] ZERO_DATA = '0;

    // Address width for a given depth; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage : rf_pkg

// File: rtl/regfile_read_mux.sv
// DEPTH-way, WIDTH-bit read mux with an in-range check.
// Addresses at or beyond DEPTH return zero data and a clear valid flag.
module regfile_read_mux
    import rf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = addr_width(DEF_DEPTH)
) (
    input  logic [DEPTH*WIDTH-1:0] regs_flat,
    input  logic [DEPTH-1:0]       valid_bits,
    input  logic [AW-1:0]          addr,
    output logic [WIDTH-1:0]       data,
    output logic                   valid
);

    logic in_range;

    assign in_range = (32'(addr) < DEPTH);

    // Select the addressed register; nothing matches when out of range.
    always_comb begin
        // NOTE: defaults first so every path assigns data/valid and no latch is inferred.
        data  = WIDTH'(ZERO_DATA);
        valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (in_range && (32'(addr) == i)) begin
                data  = regs_flat[i*WIDTH +: WIDTH];
                valid = valid_bits[i];
            end
        end
    end

endmodule : regfile_read_mux

// File: rtl/regfile_nport.sv
// Parametrised register file: NUM_RD combinational read ports, one synchronous
// write port, per-register written-valid bitmap, synchronous bulk clear and an
// optional hardwired zero register (ZERO_REG).
// Optional macro RF_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_nport
    import rf_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int NUM_RD   = DEF_NUM_RD,
    parameter  int ZERO_REG = 1,
    localparam int AW       = addr_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [NUM_RD*AW-1:0]    raddr,
    output logic [NUM_RD*WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]       rvalid
);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH*WIDTH-1:0]      regs_flat;
    logic [DEPTH-1:0]            valid_bits;
    logic                        write_ok;

    // A write lands only for an in-range address that is not the zero register.
    assign write_ok = we && (32'(waddr) < DEPTH) &&
                      !((ZERO_REG != 0) && (waddr == '0));

    assign regs_flat = regs;

    // Storage and valid bitmap: async reset, clear beats write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the whole array is reset so no read can ever return X.
            regs       <= '0;
            valid_bits <= '0;
        end else if (clr) begin
            regs       <= '0;
            valid_bits <= '0;
        end else if (write_ok) begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            regs[waddr]       <= wdata;
            valid_bits[waddr] <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_port
        logic [AW-1:0]    port_addr;
        logic [WIDTH-1:0] mux_data;
        logic             mux_valid;
        logic [WIDTH-1:0] port_data;
        logic             port_valid;

        assign port_addr = raddr[g*AW +: AW];

        regfile_read_mux #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_mux (
            .regs_flat  (regs_flat),
            .valid_bits (valid_bits),
            .addr       (port_addr),
            .data       (mux_data),
            .valid      (mux_valid)
        );

        // Post-mux overrides: optional forwarding, then the zero register wins.
        always_comb begin
            port_data  = mux_data;
            port_valid = mux_valid;
`ifdef RF_BYPASS_EN
            if (rst_n && !clr && write_ok && (waddr == port_addr)) begin
                port_data  = wdata;
                port_valid = 1'b1;
            end
`endif
            if ((ZERO_REG != 0) && (port_addr == '0)) begin
                port_data  = WIDTH'(ZERO_DATA);
                port_valid = 1'b1;
            end
        end

        assign rdata[g*WIDTH +: WIDTH] = port_data;
        assign rvalid[g]               = port_valid;
    end

endmodule : regfile_nport
